// File: rtl/gen1_skp_insert_if.sv
// Stream interface between the MAC, the SKP inserter and the Gen1 scrambler.
// The input half carries MAC TLP/DLLP words with a valid/ready handshake;
// the output half carries symbols to the scrambler without backpressure.
interface gen1_skp_insert_if;
    logic [31:0] data_in;
    logic [3:0]  data_k_in;
    logic        data_valid;
    logic        data_last;
    logic        data_ready;
    logic [31:0] data_out;
    logic [3:0]  data_k_out;
    logic        data_valid_out;

    // Inserter side: consumes MAC words, produces scrambler symbols
    modport slave (
        input  data_in,
        input  data_k_in,
        input  data_valid,
        input  data_last,
        output data_ready,
        output data_out,
        output data_k_out,
        output data_valid_out
    );

    // Environment side: MAC source plus scrambler sink
    modport master (
        output data_in,
        output data_k_in,
        output data_valid,
        output data_last,
        input  data_ready,
        input  data_out,
        input  data_k_out,
        input  data_valid_out
    );
endinterface

// File: rtl/gen1_skp_insert.sv
// Gen1 TX SKP ordered-set inserter, placed directly upstream of the scrambler.
// Passes MAC words through with one cycle of latency and inserts
// COM,SKP,SKP,SKP ordered sets at packet boundaries on a symbol-time schedule.
// Optional build macro GEN1_SKP_FORCE_EN adds skp_force_i, which schedules an
// extra ordered set exactly like a timer event.
module gen1_skp_insert #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned MAX_PENDING  = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [5:0]                       pipe_width_i,
`ifdef GEN1_SKP_FORCE_EN
    input  logic                             skp_force_i,
`endif
    gen1_skp_insert_if.slave                 bus,
    output logic [$clog2(MAX_PENDING+1)-1:0] skp_pending_o
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned PSUM_W = PEND_W + 2;
    localparam logic [7:0]  SYM_COM = 8'hBC;
    localparam logic [7:0]  SYM_SKP = 8'h1C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_SKP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PEND_W-1:0]   pend_q;
    logic [2:0]          skp_b_q;
    logic [1:0]          sym_idx_q;
    logic [31:0]         data_q;
    logic [3:0]          k_q;
    logic                valid_q;

    logic [2:0]          b_cur;
    logic [3:0]          lane_m;
    logic [31:0]         pass_data;
    logic [3:0]          pass_k;
    logic [CNT_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                sched;
    logic                force_req;
    logic [1:0]          inc;
    logic                os_last;
    logic                more_os;
    logic [PSUM_W-1:0]   pend_dec;
    logic [PSUM_W-1:0]   pend_sum;
    logic [PEND_W-1:0]   pend_nxt;
    logic                ready_c;
    logic                accept;
    logic [35:0]         os_start_word;
    logic [35:0]         os_next_word;
    logic [1:0]          sym_idx_nxt;

    // {K, data} for the OS symbols starting at idx, b lanes wide, unused lanes 0
    function automatic logic [35:0] os_word(input logic [2:0] b, input logic [1:0] idx);
        logic [31:0] d;
        logic [3:0]  k;
        d = '0;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < b) begin
                d[8*i +: 8] = ((idx == 2'd0) && (i == 0)) ? SYM_COM : SYM_SKP;
                k[i]        = 1'b1;
            end
        end
        return {k, d};
    endfunction

    // Bytes per cycle from the PIPE width; anything unrecognised behaves as 32 bits
    always_comb begin
        b_cur  = 3'd4;
        lane_m = 4'b1111;
        case (pipe_width_i)
            6'd8:    begin b_cur = 3'd1; lane_m = 4'b0001; end
            6'd16:   begin b_cur = 3'd2; lane_m = 4'b0011; end
            default: begin b_cur = 3'd4; lane_m = 4'b1111; end
        endcase
    end

`ifdef GEN1_SKP_FORCE_EN
    assign force_req = skp_force_i;
`else
    assign force_req = 1'b0;
`endif

    // Passthrough word with lanes beyond the current width zeroed
    assign pass_data = bus.data_in & {{8{lane_m[3]}}, {8{lane_m[2]}},
                                      {8{lane_m[1]}}, {8{lane_m[0]}}};
    assign pass_k    = bus.data_k_in & lane_m;

    // Symbol-time schedule: one event each time the running count crosses the interval
    assign cnt_sum = cnt_q + CNT_W'(b_cur);
    assign sched   = (cnt_sum >= CNT_W'(SKP_INTERVAL));
    assign cnt_nxt = sched ? (cnt_sum - CNT_W'(SKP_INTERVAL)) : cnt_sum;
    assign inc     = {1'b0, sched} + {1'b0, force_req};

    // Pending count: completion decrements first, then new events saturate
    assign os_last  = (state_q == ST_SKP) &&
                      (({2'b00, sym_idx_q} + {1'b0, skp_b_q}) >= 4'd4);
    assign more_os  = (pend_q != PEND_W'(1));
    assign pend_dec = PSUM_W'(pend_q) - PSUM_W'(os_last);
    assign pend_sum = pend_dec + PSUM_W'(inc);
    assign pend_nxt = (pend_sum > PSUM_W'(MAX_PENDING)) ? PEND_W'(MAX_PENDING)
                                                        : pend_sum[PEND_W-1:0];

    // Input accept: open inside a packet, or between packets with nothing owed
    assign ready_c = !rst_i && ((state_q == ST_PKT) ||
                                ((state_q == ST_IDLE) && (pend_q == '0)));
    assign accept  = ready_c && bus.data_valid;

    // OS symbol words for starting a fresh set and for continuing the current one
    assign os_start_word = os_word(b_cur, 2'd0);
    assign sym_idx_nxt   = sym_idx_q + skp_b_q[1:0];
    assign os_next_word  = os_word(skp_b_q, sym_idx_nxt);

    // Scheduler, FSM and registered output stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            skp_b_q   <= 3'd0;
            sym_idx_q <= 2'd0;
            data_q    <= '0;
            k_q       <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            pend_q  <= pend_nxt;
            data_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q != '0) begin
                        state_q          <= ST_SKP;
                        skp_b_q          <= b_cur;
                        sym_idx_q        <= 2'd0;
                        {k_q, data_q}    <= os_start_word;
                        valid_q          <= 1'b1;
                    end else if (accept) begin
                        data_q  <= pass_data;
                        k_q     <= pass_k;
                        valid_q <= 1'b1;
                        if (!bus.data_last) begin
                            state_q <= ST_PKT;
                        end
                    end
                end
                ST_PKT: begin
                    if (accept) begin
                        data_q  <= pass_data;
                        k_q     <= pass_k;
                        valid_q <= 1'b1;
                        if (bus.data_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_SKP: begin
                    if (os_last) begin
                        if (more_os) begin
                            skp_b_q       <= b_cur;
                            sym_idx_q     <= 2'd0;
                            {k_q, data_q} <= os_start_word;
                            valid_q       <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        sym_idx_q     <= sym_idx_nxt;
                        {k_q, data_q} <= os_next_word;
                        valid_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_ready     = ready_c;
    assign bus.data_out       = data_q;
    assign bus.data_k_out     = k_q;
    assign bus.data_valid_out = valid_q;
    assign skp_pending_o      = pend_q;

endmodule

// File: tb/tb_gen1_skp_insert.sv
// Self-checking bench for gen1_skp_insert: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a symbol-count model.
module tb_gen1_skp_insert;

    localparam int SKP_INT = 16;
    localparam int MAX_P   = 2;
    localparam int CNT_W   = 16;
    localparam int PEND_W  = $clog2(MAX_P + 1);
    localparam logic [31:0] OS32 = 32'h1C1C1CBC;

    logic              clk;
    logic              rst;
    logic [5:0]        pw;
    logic              skp_force;
    logic [PEND_W-1:0] pend_o;

    gen1_skp_insert_if bus();

    gen1_skp_insert #(
        .SKP_INTERVAL(SKP_INT),
        .MAX_PENDING (MAX_P),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pipe_width_i (pw),
`ifdef GEN1_SKP_FORCE_EN
        .skp_force_i  (skp_force),
`endif
        .bus          (bus),
        .skp_pending_o(pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: symbols-owed bookkeeping rather than a state machine
    int          m_cnt       = 0;
    int          m_pend      = 0;
    int          m_os_n      = 0;
    int          m_os_b      = 4;
    bit          m_in_pkt    = 0;
    bit          m_os_active = 0;
    logic [31:0] m_data      = '0;
    logic [3:0]  m_k         = '0;
    logic        m_valid     = 1'b0;

    logic [31:0] words [0:31];

    function automatic int lanes(input logic [5:0] w);
        if (w == 6'd8)  return 1;
        if (w == 6'd16) return 2;
        return 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int b, inc, dec, sum;
        logic [31:0] nd;
        logic [3:0]  nk;
        logic        nv;
        bit          emit;
        nd = '0; nk = '0; nv = 1'b0; emit = 0; dec = 0; inc = 0;
        if (rst) begin
            m_cnt = 0; m_pend = 0; m_in_pkt = 0; m_os_active = 0; m_os_n = 0; m_os_b = 4;
        end else begin
            b = lanes(pw);
            if (m_cnt + b >= SKP_INT) begin
                m_cnt = m_cnt + b - SKP_INT;
                inc = 1;
            end else begin
                m_cnt = m_cnt + b;
            end
            if (skp_force) inc++;
            if (m_os_active) begin
                if (m_os_n >= 4) begin
                    dec = 1;
                    if (m_pend - 1 != 0) begin
                        m_os_b = b; m_os_n = 0; emit = 1;
                    end else begin
                        m_os_active = 0;
                    end
                end else begin
                    emit = 1;
                end
            end else if (!m_in_pkt && m_pend != 0) begin
                m_os_active = 1; m_os_b = b; m_os_n = 0; emit = 1;
            end else if (bus.data_valid) begin
                for (int j = 0; j < b; j++) begin
                    nd[8*j +: 8] = bus.data_in[8*j +: 8];
                    nk[j]        = bus.data_k_in[j];
                end
                nv = 1'b1;
                m_in_pkt = !bus.data_last;
            end
            if (emit) begin
                for (int j = 0; j < m_os_b; j++) begin
                    nd[8*j +: 8] = (m_os_n + j == 0) ? 8'hBC : 8'h1C;
                    nk[j]        = 1'b1;
                end
                m_os_n = m_os_n + m_os_b;
                nv = 1'b1;
            end
            sum = m_pend - dec + inc;
            m_pend = (sum > MAX_P) ? MAX_P : sum;
        end
        m_data = nd; m_k = nk; m_valid = nv;
    endtask

    // One clock: check ready before the edge, registered outputs after it
    task automatic cycle();
        bit er;
        #2;
        er = !rst && !m_os_active && (m_in_pkt || m_pend == 0);
        check("ready", 32'(bus.data_ready), 32'(er));
        model_step();
        @(posedge clk);
        #1;
        check("data", bus.data_out, m_data);
        check("k", 32'(bus.data_k_out), 32'(m_k));
        check("valid", 32'(bus.data_valid_out), 32'(m_valid));
        check("pending", 32'(pend_o), 32'(m_pend));
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.data_in    = '0;
        bus.data_k_in  = '0;
        skp_force      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int found;
        int sel;
        rst = 1'b1;
        pw  = 6'd32;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset state
        repeat (3) cycle();
        check("rst_valid", 32'(bus.data_valid_out), 32'd0);
        check("rst_pending", 32'(pend_o), 32'd0);

        // Idle traffic, 4 lanes: one OS once the first schedule event lands
        rst = 1'b0;
        repeat (4) cycle();
        check("t1_pend1", 32'(pend_o), 32'd1);
        cycle();
        check("t1_os_data", bus.data_out, OS32);
        check("t1_os_k", 32'(bus.data_k_out), 32'hF);
        check("t1_os_ready", 32'(bus.data_ready), 32'd0);
        cycle();
        check("t1_pend0", 32'(pend_o), 32'd0);
        check("t1_valid0", 32'(bus.data_valid_out), 32'd0);
        repeat (6) cycle();

        // 10-word packet from cycle 0; OS only after the last word
        do_reset();
        for (int i = 0; i < 10; i++) begin
            words[i]       = $urandom;
            bus.data_valid = 1'b1;
            bus.data_in    = words[i];
            bus.data_k_in  = 4'($urandom);
            bus.data_last  = (i == 9);
            cycle();
        end
        idle_inputs();
        check("t2_last_word", bus.data_out, words[9]);
        cycle();
        check("t2_os_after", bus.data_out, OS32);
        repeat (8) cycle();

        // Single lane: BC,1C,1C,1C on consecutive cycles
        pw = 6'd8;
        do_reset();
        repeat (17) cycle();
        check("t3_com", bus.data_out, 32'h000000BC);
        check("t3_com_k", 32'(bus.data_k_out), 32'h1);
        repeat (3) cycle();
        check("t3_skp3", bus.data_out, 32'h0000001C);
        repeat (6) cycle();

        // Long packet: pending saturates, then back-to-back OS words
        pw = 6'd32;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = $urandom;
            bus.data_k_in  = 4'($urandom);
            bus.data_last  = (i == 23);
            cycle();
            if (i == 19) check("t4_sat", 32'(pend_o), 32'(MAX_P));
        end
        idle_inputs();
        cycle();
        check("t4_os1", bus.data_out, OS32);
        cycle();
        check("t4_os2", bus.data_out, OS32);
        cycle();
        check("t4_gap", 32'(bus.data_valid_out), 32'd0);
        check("t4_ready", 32'(bus.data_ready), 32'd1);
        repeat (4) cycle();

        // Reset in the middle of a single-lane OS
        pw = 6'd8;
        do_reset();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_os_active && m_os_n == 2) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("t5_reached", 32'(found), 32'd1);
        rst = 1'b1;
        cycle();
        check("t5_data0", bus.data_out, 32'd0);
        check("t5_valid0", 32'(bus.data_valid_out), 32'd0);
        check("t5_pend0", 32'(pend_o), 32'd0);
        rst = 1'b0;
        repeat (24) cycle();

`ifdef GEN1_SKP_FORCE_EN
        // Forced OS from an idle, empty state; timer schedule unaffected
        pw = 6'd32;
        do_reset();
        skp_force = 1'b1;
        cycle();
        skp_force = 1'b0;
        cycle();
        check("t6_force_os", bus.data_out, OS32);
        check("t6_force_valid", 32'(bus.data_valid_out), 32'd1);
        repeat (3) cycle();
        check("t6_timer_os", bus.data_out, OS32);
        repeat (4) cycle();
`endif

        // Randomized traffic, widths, forces and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (!m_in_pkt && $urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 7);
                if (sel < 2)      pw = 6'd8;
                else if (sel < 4) pw = 6'd16;
                else if (sel < 7) pw = 6'd32;
                else              pw = 6'd24;
            end
            rst            = ($urandom_range(0, 199) == 0);
            bus.data_valid = ($urandom_range(0, 3) != 0);
            bus.data_last  = ($urandom_range(0, 5) == 0);
            bus.data_in    = $urandom;
            bus.data_k_in  = 4'($urandom);
`ifdef GEN1_SKP_FORCE_EN
            skp_force      = ($urandom_range(0, 40) == 0);
`endif
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
